alu_issue: RTL and testbench
============================

# alu_issue

Decode-to-execute issue stage feeding the ALU. Accepts one RV32I OP/OP-IMM instruction per cycle with its register-file read data, decodes the 4-bit ALU control code and selects operands, and presents them through a registered valid/ready interface with a two-entry skid buffer. Sits between register-file read and the ALU, giving full throughput under back-pressure with all outputs driven directly from flops.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  instruction/data valid
- in_ready  out  1  stage can accept; registered
- instr  in  32  raw instruction word
- rs1_data  in  32  register-file read of instr[19:15]
- rs2_data  in  32  register-file read of instr[24:20]
- out_valid  out  1  issue entry valid
- out_ready  in  1  ALU/execute accepts entry
- operand_a  out  32  to ALU operand_a
- operand_b  out  32  to ALU operand_b
- alu_control  out  4  to ALU control
- rd  out  5  destination register, instr[11:7]
- illegal  out  1  instruction not a supported OP/OP-IMM

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, SLTU 0011, SUB 0110, SLT 0111, XOR 1000, SLL 1001, SRL 1010, SRA 1011.
- Opcode 0110011 (OP): operand_a=rs1_data, operand_b=rs2_data.
- Opcode 0010011 (OP-IMM): operand_a=rs1_data, operand_b=sign-extended instr[31:20]; shifts use operand_b={27'b0, instr[24:20]}.
- funct3 000: ADD; SUB only for OP with funct7=0100000. OP-IMM ignores funct7.
- funct3 001: SLL, funct7 must be 0000000.
- funct3 101: SRL for funct7=0000000, SRA for 0100000.
- funct3 010/011/100/110/111: SLT/SLTU/XOR/OR/AND; for OP, funct7 must be 0000000.
- Any other opcode or funct7: illegal=1, alu_control=ADD, operands 0, rd passed through. Entry still flows; never dropped.
- Decode is combinational on the input side; only decoded results are stored.

## Timing
- Accept on in_valid && in_ready; deliver on out_valid && out_ready.
- Latency: entry accepted in cycle N is presented at the outputs in cycle N+1.
- Throughput 1/cycle while out_ready=1.
- Buffer states: EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept and deliver -> ONE (main reloads); accept only -> TWO (skid loads); deliver only -> EMPTY.
  - TWO: deliver -> ONE (skid moves to main); no accept possible.
- in_ready = (state != TWO), registered.
- Outputs hold stable while out_valid && !out_ready.
- Order is preserved.
- flush: next state EMPTY, in_ready=1; flush wins over a simultaneous accept (input discarded) and a simultaneous delivery (delivery still counts as taken).
- Reset values: out_valid=0, in_ready=1, operand_a=0, operand_b=0, alu_control=0000, rd=0, illegal=0. Reset mid-operation clears both entries immediately (asynchronously).

## Structure
- Shared package `alu_pkg`: alu_control code constants (`alu_op_e` enum, 4-bit), opcode constants (OPC_OP, OPC_OP_IMM), funct7 constants, and a packed `issue_entry_t` {operand_a, operand_b, alu_control, rd, illegal}.
- The ALU uses the same enum; SLTU is 0011.
- Sub-module `alu_decode`: purely combinational, maps instr/rs1_data/rs2_data to `issue_entry_t`.
- The top level holds the two-entry skid buffer and FSM.

## Test plan
- ADD: instr=0x002081B3, rs1=5, rs2=7 -> next cycle operand_a=5, operand_b=7, alu_control=0010, rd=3, illegal=0.
- SUB: instr=0x402081B3 -> alu_control=0110. SRAI: instr=0x40435293, rs1=0x80000000 -> alu_control=1011, operand_b=4, rd=5.
- ADDI x1,x0,-1: instr=0xFFF00093, rs1=0 -> operand_b=0xFFFFFFFF, alu_control=0010.
- Back-pressure: in_valid held high with distinct entries, out_ready=0 for 3 cycles -> exactly 2 accepted, in_ready=0, outputs stable; then out_ready=1 -> both drain in order, in_ready returns to 1.
- Illegal: instr=0x0000007F, and instr=0x222081B3 -> illegal=1, alu_control=0010, operands 0.
- Flush/reset: with state TWO, assert flush with in_valid=1 -> out_valid=0 next cycle, input dropped. Repeat with rst_n pulsed low mid-cycle -> out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, opcode/funct7 constants and the issue entry payload.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    alu_op_e         alu_control;
    logic [REGW-1:0] rd;
    logic            illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational OP/OP-IMM decoder producing one issue entry from the instruction and RF data.
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_entry_t    entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_imm;
  logic       legal;
  alu_op_e    op;
  logic       unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);
  // Register index fields are consumed by the register file upstream.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    op    = ALU_ADD;
    legal = 1'b0;
    case (funct3)
      3'b000: begin
        op    = (is_op && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        legal = is_imm || funct7 == F7_ZERO || funct7 == F7_ALT;
      end
      3'b001: begin
        op    = ALU_SLL;
        legal = (funct7 == F7_ZERO);
      end
      3'b101: begin
        op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      end
      3'b010: begin op = ALU_SLT;  legal = is_imm || funct7 == F7_ZERO; end
      3'b011: begin op = ALU_SLTU; legal = is_imm || funct7 == F7_ZERO; end
      3'b100: begin op = ALU_XOR;  legal = is_imm || funct7 == F7_ZERO; end
      3'b110: begin op = ALU_OR;   legal = is_imm || funct7 == F7_ZERO; end
      default: begin op = ALU_AND; legal = is_imm || funct7 == F7_ZERO; end
    endcase
  end

  // Illegal entries still flow, as a zero-operand ADD flagged illegal.
  always_comb begin
    entry             = '0;
    entry.alu_control = ALU_ADD;
    entry.rd          = instr[11:7];
    entry.illegal     = 1'b1;
    if ((is_op || is_imm) && legal) begin
      entry.illegal     = 1'b0;
      entry.alu_control = op;
      entry.operand_a   = rs1_data;
      if (is_op) begin
        entry.operand_b = rs2_data;
      end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
        entry.operand_b = {27'b0, instr[24:20]};
      end else begin
        entry.operand_b = {{20{instr[31]}}, instr[31:20]};
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes one instruction per cycle into a two-entry skid buffer with registered outputs.
module alu_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  output logic [REGW-1:0] rd,
  output logic            illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e   state_q, state_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  issue_entry_t dec_entry;
  logic         accept;
  logic         deliver;

  alu_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .entry    (dec_entry)
  );

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Flush overrides any accept; a coincident delivery is simply consumed.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            main_d = dec_entry;
          end else if (accept) begin
            skid_d  = dec_entry;
            state_d = ST_TWO;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign operand_a   = main_q.operand_a;
  assign operand_b   = main_q.operand_b;
  assign alu_control = main_q.alu_control;
  assign rd          = main_q.rd;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, back-pressure, flush and async reset.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control),
    .rd          (rd),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
  endtask

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs1_data = '0; rs2_data = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_opa",       operand_a,      32'd0);
    check("rst_opb",       operand_b,      32'd0);
    check("rst_ctrl",      32'(alu_control), 32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    rst_n = 1'b1;
    step();

    // Decode vectors at full throughput
    drive(ADD_X3, 32'd5, 32'd7); step();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_opa",   operand_a, 32'd5);
    check("add_opb",   operand_b, 32'd7);
    check("add_ctrl",  32'(alu_control), 32'h2);
    check("add_rd",    32'(rd), 32'd3);
    check("add_ill",   32'(illegal), 32'd0);

    drive(32'h402081B3, 32'd5, 32'd7); step();
    check("sub_ctrl", 32'(alu_control), 32'h6);
    check("sub_opb",  operand_b, 32'd7);

    drive(32'h40435293, 32'h8000_0000, 32'h1234); step();
    check("srai_ctrl", 32'(alu_control), 32'hB);
    check("srai_opa",  operand_a, 32'h8000_0000);
    check("srai_opb",  operand_b, 32'd4);
    check("srai_rd",   32'(rd), 32'd5);

    drive(32'hFFF00093, 32'd0, 32'd9); step();
    check("addi_opb",  operand_b, 32'hFFFF_FFFF);
    check("addi_ctrl", 32'(alu_control), 32'h2);
    check("addi_rd",   32'(rd), 32'd1);

    drive(32'h0020B1B3, 32'd11, 32'd12); step();
    check("sltu_ctrl", 32'(alu_control), 32'h3);
    check("sltu_opb",  operand_b, 32'd12);

    drive(32'h0000007F, 32'd5, 32'd7); step();
    check("ill_opc_flag", 32'(illegal), 32'd1);
    check("ill_opc_ctrl", 32'(alu_control), 32'h2);
    check("ill_opc_opa",  operand_a, 32'd0);
    check("ill_opc_opb",  operand_b, 32'd0);

    drive(32'h222081B3, 32'd5, 32'd7); step();
    check("ill_f7_flag", 32'(illegal), 32'd1);
    check("ill_f7_ctrl", 32'(alu_control), 32'h2);
    check("ill_f7_opa",  operand_a, 32'd0);
    check("ill_f7_rd",   32'(rd), 32'd3);

    in_valid = 1'b0; step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);

    // Back-pressure: three stalled cycles, only two entries fit
    out_ready = 1'b0;
    drive(ADD_X3, 32'd100, 32'd0); step();
    check("bp1_opa",   operand_a, 32'd100);
    check("bp1_ready", 32'(in_ready), 32'd1);
    drive(ADD_X3, 32'd101, 32'd0); step();
    check("bp2_opa",   operand_a, 32'd100);
    check("bp2_ready", 32'(in_ready), 32'd0);
    drive(ADD_X3, 32'd102, 32'd0); step();
    check("bp3_opa",   operand_a, 32'd100);
    check("bp3_valid", 32'(out_valid), 32'd1);
    check("bp3_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("bp_drain1_opa",   operand_a, 32'd101);
    check("bp_drain1_valid", 32'(out_valid), 32'd1);
    check("bp_drain1_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_drain2_valid", 32'(out_valid), 32'd0);

    // Flush from TWO with a simultaneous accept attempt and delivery
    out_ready = 1'b0;
    drive(ADD_X3, 32'd200, 32'd0); step();
    drive(ADD_X3, 32'd201, 32'd0); step();
    check("fl_pre_ready", 32'(in_ready), 32'd0);
    drive(ADD_X3, 32'd202, 32'd0); flush = 1'b1; out_ready = 1'b1; step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; step();
    check("fl_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle from TWO
    out_ready = 1'b0;
    drive(ADD_X3, 32'd300, 32'd0); step();
    drive(ADD_X3, 32'd301, 32'd0); step();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_opa",   operand_a, 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_post_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
